draw_player: RTL and testbench
==============================

# draw_player

Overlay stage placed directly after the game background/character drawer in the VGA pipeline. Consumes the composed `vga_if` stream and paints a movable player rectangle on top. Position updates once per frame from left/right/jump inputs, with a jump/gravity state machine. Re-emits the stream with one cycle of latency.

## Interface

**Parameters**
- `X_INIT`, default 100: reset horizontal position (left edge, px).
- `Y_GROUND`, default 600: top-edge y when standing on the ground.
- `WIDTH`, default 32: sprite width (px).
- `HEIGHT`, default 48: sprite height (px).
- `COLOR`, default 12'hF00: sprite fill colour.
- `STEP`, default 4: horizontal px per frame.
- `JUMP_V0`, default 16: initial upward speed (px/frame).
- `GRAVITY`, default 1: speed change per frame.
- `SCREEN_W`, default 1024: active width, used for clamping.

**Ports**
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `left` in 1: level, move left; already synchronous to `clk`.
- `right` in 1: level, move right.
- `jump` in 1: level, request jump.
- `in` vga_if.in: `hcount`/`vcount` 11b, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb` 12b.
- `out` vga_if.out: same fields.

## Operation

**Frame tick**
- `tick` is the rising edge of `in.vblnk`: `in.vblnk`=1 while the registered previous value is 0.
- All position/state updates happen only on `tick`, inside blanking, so there is no tearing.

**Horizontal movement (on tick)**
- If `left`=1 and `right`=0: x -= STEP, saturating at 0.
- If `right`=1 and `left`=0: x += STEP, saturating at SCREEN_W-WIDTH.
- If both or neither are set: x is held.

**Vertical state machine (on tick)**
- Registers: `y` 11b, `vy` 8b unsigned.
- GROUND: y=Y_GROUND, vy=0.
  - `jump`=1 → RISING, with y=Y_GROUND-JUMP_V0 and vy=JUMP_V0-GRAVITY.
- RISING: y -= vy, vy -= GRAVITY.
  - If vy-GRAVITY ≤ 0 → FALLING, vy=0.
  - `jump` is ignored.
- FALLING: vy += GRAVITY, y += new vy.
  - If y+new vy ≥ Y_GROUND: y=Y_GROUND, vy=0 → GROUND.
- Horizontal movement continues in every state.

**Drawing**
- hit = (in.hcount ≥ x) && (in.hcount < x+WIDTH) && (in.vcount ≥ y) && (in.vcount < y+HEIGHT).
- If hit and not blanked (`hblnk`=0, `vblnk`=0): out.rgb=COLOR.
- Otherwise out.rgb=in.rgb.
- Compare widths: 12b so x+WIDTH cannot overflow.

## Timing

- Latency: 1 clock. All `out` sync/blank/count fields are `in` delayed by 1 register stage.
- `out.rgb` is derived from the same-cycle `in` sample and the current x/y.
- Reset values:
  - All `out` fields = 0.
  - x=X_INIT, y=Y_GROUND, vy=0, state=GROUND, previous-vblnk register=0.
- Position registers change only on the cycle after a `tick`, and stay stable for the whole active frame.
- Reset mid-jump: the next cycle shows the reset values. No tick is generated by the `vblnk` edge that follows reset release unless a real 0→1 transition occurs.
- Simultaneous `left`+`right`+`jump` at a tick: x held, jump accepted if in GROUND.

## Configuration

- `PLAYER_OUTLINE_EN` defined:
  - Sprite pixels on the outer 1-px border draw 12'h000: hcount==x, hcount==x+WIDTH-1, vcount==y, or vcount==y+HEIGHT-1.
  - Interior pixels draw COLOR.
- `PLAYER_OUTLINE_EN` undefined: the whole rectangle is COLOR.
- Latency is unchanged in both cases.

## Test plan

- Reset then an idle frame at defaults:
  - pixel (100,600) → rgb 12'hF00 (12'h000 with outline).
  - (116,620) → 12'hF00.
  - (132,620) → passthrough `in.rgb`.
  - All sync/blank fields delayed exactly 1 cycle.
- `right` held for 3 ticks → x=112. `left`+`right` held for 1 tick → x stays 112.
- `left` held for 30 ticks from x=100 → x=0 (saturates). `right` held long → x=992.
- `jump` pulse across 1 tick:
  - y sequence 584, 569, … apex 464 after 16 ticks.
  - Returns to y=600/GROUND after 32 ticks total.
  - A `jump` asserted during RISING has no effect.
- Assert `rst` at tick 8 of a jump → next cycle x=100, y=600, GROUND, all outputs 0.
- Pixel inside the sprite with `in.hblnk`=1 → out.rgb equals `in.rgb` (no paint).

Source files
------------

// File: rtl/draw_player_if.sv
// vga_if: one pixel of a VGA timing/colour stream (counters, syncs, blanks, 12-bit rgb).
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// draw_player: paints a movable, jumping player rectangle over a vga_if stream, 1-cycle latency.
// Build option: define PLAYER_OUTLINE_EN to draw a 1-px black border around the sprite.
module draw_player #(
   parameter int unsigned X_INIT   = 100,
   parameter int unsigned Y_GROUND = 600,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned HEIGHT   = 48,
   parameter logic [11:0] COLOR    = 12'hF00,
   parameter int unsigned STEP     = 4,
   parameter int unsigned JUMP_V0  = 16,
   parameter int unsigned GRAVITY  = 1,
   parameter int unsigned SCREEN_W = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic left,
   input  logic right,
   input  logic jump,
   vga_if.in    in,
   vga_if.out   out
);

   typedef enum logic [1:0] {GROUND, RISING, FALLING} state_e;

   localparam logic [11:0] X_MAX_W  = 12'(SCREEN_W - WIDTH);
   localparam logic [11:0] STEP_W   = 12'(STEP);
   localparam logic [11:0] WIDTH_W  = 12'(WIDTH);
   localparam logic [11:0] HEIGHT_W = 12'(HEIGHT);
   localparam logic [11:0] YGND_W   = 12'(Y_GROUND);
   localparam logic [10:0] X_INIT_C = 11'(X_INIT);
   localparam logic [10:0] YGND_C   = 11'(Y_GROUND);
   localparam logic [10:0] Y_JUMP_C = 11'(Y_GROUND - JUMP_V0);
   localparam logic [7:0]  VY_JUMP  = 8'(JUMP_V0 - GRAVITY);
   localparam logic [7:0]  GRAV_C   = 8'(GRAVITY);

   state_e      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [7:0]  vy_q, vy_d;
   logic [7:0]  vy_fall;
   logic        vblnk_prev_q;
   logic        tick;

   logic [10:0] hcount_q, vcount_q;
   logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
   logic [11:0] rgb_q, rgb_d;

   logic [11:0] h_w, v_w, x_w, y_w;
   logic        hit, edge_px;

   assign tick    = in.vblnk & ~vblnk_prev_q;
   assign vy_fall = vy_q + GRAV_C;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vy_d    = vy_q;
      if (tick) begin
         if (left && !right) begin
            x_d = ({1'b0, x_q} >= STEP_W) ? x_q - STEP_W[10:0] : 11'd0;
         end else if (right && !left) begin
            x_d = ({1'b0, x_q} + STEP_W > X_MAX_W) ? X_MAX_W[10:0] : x_q + STEP_W[10:0];
         end

         unique case (state_q)
            GROUND: begin
               if (jump) begin
                  state_d = RISING;
                  y_d     = Y_JUMP_C;
                  vy_d    = VY_JUMP;
               end
            end
            RISING: begin
               y_d = y_q - {3'd0, vy_q};
               // vy is unsigned, so "vy - GRAVITY <= 0" becomes "vy <= GRAVITY".
               if (vy_q <= GRAV_C) begin
                  state_d = FALLING;
                  vy_d    = 8'd0;
               end else begin
                  vy_d = vy_q - GRAV_C;
               end
            end
            FALLING: begin
               if ({1'b0, y_q} + {4'd0, vy_fall} >= YGND_W) begin
                  state_d = GROUND;
                  y_d     = YGND_C;
                  vy_d    = 8'd0;
               end else begin
                  y_d  = y_q + {3'd0, vy_fall};
                  vy_d = vy_fall;
               end
            end
            default: state_d = GROUND;
         endcase
      end
   end

   always_comb begin
      h_w     = {1'b0, in.hcount};
      v_w     = {1'b0, in.vcount};
      x_w     = {1'b0, x_q};
      y_w     = {1'b0, y_q};
      hit     = (h_w >= x_w) && (h_w < x_w + WIDTH_W) &&
                (v_w >= y_w) && (v_w < y_w + HEIGHT_W);
      edge_px = (h_w == x_w) || (h_w == x_w + WIDTH_W - 12'd1) ||
                (v_w == y_w) || (v_w == y_w + HEIGHT_W - 12'd1);
      rgb_d   = in.rgb;
      if (hit && !in.hblnk && !in.vblnk) begin
`ifdef PLAYER_OUTLINE_EN
         rgb_d = edge_px ? 12'h000 : COLOR;
`else
         rgb_d = COLOR;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= GROUND;
         x_q          <= X_INIT_C;
         y_q          <= YGND_C;
         vy_q         <= 8'd0;
         vblnk_prev_q <= 1'b0;
         hcount_q     <= '0;
         vcount_q     <= '0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vy_q         <= vy_d;
         vblnk_prev_q <= in.vblnk;
         hcount_q     <= in.hcount;
         vcount_q     <= in.vcount;
         hsync_q      <= in.hsync;
         vsync_q      <= in.vsync;
         hblnk_q      <= in.hblnk;
         vblnk_q      <= in.vblnk;
         rgb_q        <= rgb_d;
      end
   end

   assign out.hcount = hcount_q;
   assign out.vcount = vcount_q;
   assign out.hsync  = hsync_q;
   assign out.vsync  = vsync_q;
   assign out.hblnk  = hblnk_q;
   assign out.vblnk  = vblnk_q;
   assign out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: directed checks of draw_player pixel painting, movement, jump physics and reset.
module tb_draw_player;

   localparam logic [11:0] COLOR = 12'hF00;
   localparam logic [11:0] BG    = 12'h5A5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic left = 1'b0, right = 1'b0, jump = 1'b0;
   int   checks = 0;
   int   errors = 0;

   vga_if vin();
   vga_if vout();

   draw_player dut (
      .clk  (clk),
      .rst  (rst),
      .left (left),
      .right(right),
      .jump (jump),
      .in   (vin),
      .out  (vout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pix(input int h, input int v, input logic hb, output logic [11:0] rgb_o);
      @(negedge clk);
      vin.hcount = 11'(h);
      vin.vcount = 11'(v);
      vin.hblnk  = hb;
      vin.vblnk  = 1'b0;
      vin.rgb    = BG;
      @(posedge clk);
      #1 rgb_o = vout.rgb;
   endtask

   task automatic check_pix(input string tag, input int h, input int v, input logic [11:0] exp);
      logic [11:0] r;
      pix(h, v, 1'b0, r);
      check(tag, {20'd0, r}, {20'd0, exp});
   endtask

   // Pins the sprite's top-left corner exactly by probing just inside and just outside each side.
   task automatic check_pos(input string tag, input int x, input int y);
      check_pix({tag, ".in"}, x + 1, y + 1, COLOR);
      if (x > 0) check_pix({tag, ".lft"}, x - 1, y + 1, BG);
      check_pix({tag, ".rgt"}, x + 32, y + 1, BG);
      check_pix({tag, ".top"}, x + 1, y - 1, BG);
      check_pix({tag, ".bot"}, x + 1, y + 48, BG);
   endtask

   task automatic frame_tick(input logic l, input logic r, input logic j);
      @(negedge clk);
      left = l; right = r; jump = j;
      vin.vblnk = 1'b1;
      @(negedge clk);
      vin.vblnk = 1'b0;
      @(negedge clk);
      left = 1'b0; right = 1'b0; jump = 1'b0;
   endtask

   initial begin
      logic [11:0] r;
      logic [11:0] corner_exp;

      vin.hcount = 11'h7FF; vin.vcount = 11'h7FF;
      vin.hsync = 1'b1; vin.vsync = 1'b1; vin.hblnk = 1'b1; vin.vblnk = 1'b0;
      vin.rgb = 12'hFFF;
      repeat (2) @(posedge clk);
      #1;
      check("rst.cnt", {10'd0, vout.hcount, vout.vcount}, 32'd0);
      check("rst.ctl", {20'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, 4'd0, 4'd0},
            32'd0);
      check("rst.rgb", {20'd0, vout.rgb}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
      @(negedge clk);
      vin.hcount = 11'h155; vin.vcount = 11'h2AA; vin.hsync = 1'b1; vin.vsync = 1'b0;
      vin.hblnk = 1'b1; vin.rgb = 12'h3C3;
      #1 check("dly.before", {10'd0, vout.hcount, vout.vcount}, 32'd0);
      @(posedge clk);
      #1;
      check("dly.cnt", {10'd0, vout.hcount, vout.vcount}, {10'd0, 11'h155, 11'h2AA});
      check("dly.ctl", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'b1010);
      check("dly.rgb", {20'd0, vout.rgb}, 32'h3C3);
      @(negedge clk);
      vin.hsync = 1'b0; vin.vsync = 1'b1; vin.hblnk = 1'b0;
      @(posedge clk);
      #1 check("dly.ctl2", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'b0100);

`ifdef PLAYER_OUTLINE_EN
      corner_exp = 12'h000;
`else
      corner_exp = COLOR;
`endif
      check_pix("pix.100_600", 100, 600, corner_exp);
      check_pix("pix.116_620", 116, 620, COLOR);
      check_pix("pix.132_620", 132, 620, BG);
      check_pix("pix.131_647", 131, 647, corner_exp);
      pix(116, 620, 1'b1, r);
      check("pix.hblnk", {20'd0, r}, {20'd0, BG});
      check_pos("idle", 100, 600);

      repeat (3) frame_tick(1'b0, 1'b1, 1'b0);
      check_pos("right3", 112, 600);
      frame_tick(1'b1, 1'b1, 1'b0);
      check_pos("both", 112, 600);
      repeat (30) frame_tick(1'b1, 1'b0, 1'b0);
      check_pos("left_sat", 0, 600);
      repeat (260) frame_tick(1'b0, 1'b1, 1'b0);
      check_pos("right_sat", 992, 600);

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_pos("rst2", 100, 600);
      frame_tick(1'b0, 1'b0, 1'b1);
      check_pos("jump.t1", 100, 584);
      frame_tick(1'b0, 1'b0, 1'b1);
      check_pos("jump.t2", 100, 569);
      repeat (14) frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("jump.apex", 100, 464);
      frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("jump.t17", 100, 465);
      repeat (14) frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("jump.t31", 100, 584);
      frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("jump.land", 100, 600);
      frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("jump.rest", 100, 600);

      frame_tick(1'b1, 1'b1, 1'b1);
      check_pos("lrj", 100, 584);
      repeat (15) frame_tick(1'b0, 1'b0, 1'b0);
      frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("lrj.fall", 100, 465);
      repeat (15) frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("lrj.land", 100, 600);

      frame_tick(1'b0, 1'b1, 1'b1);
      repeat (7) frame_tick(1'b0, 1'b1, 1'b0);
      check_pos("mid.t8", 132, 500);
      @(negedge clk);
      rst = 1'b1;
      vin.hcount = 11'd140; vin.vcount = 11'd510; vin.hsync = 1'b1; vin.vsync = 1'b1;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = BG;
      @(posedge clk);
      #1;
      check("mid.rst.cnt", {10'd0, vout.hcount, vout.vcount}, 32'd0);
      check("mid.rst.ctl", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'd0);
      check("mid.rst.rgb", {20'd0, vout.rgb}, 32'd0);
      @(negedge clk) rst = 1'b0;
      check_pos("mid.after", 100, 600);
      frame_tick(1'b0, 1'b0, 1'b0);
      check_pos("mid.ground", 100, 600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
